// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: feeds one external 1-bit ALU slice
// LSB first, threads the carry and assembles the result word.
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       operacion_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] resultado_o,
    output logic             zero_o,
    output logic             c_o,
    output logic             overflow_o,
    output logic             illegal_o,
    output logic             slice_a_o,
    output logic             slice_b_o,
    output logic             slice_c_o,
    output logic             slice_invert_o,
    output logic             slice_less_o,
    output logic [3:0]       slice_op_o,
    input  logic             slice_res_i,
    input  logic             slice_c_i,
    input  logic             slice_set_i
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SLT_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cin_msb_q, cout_q, set_q;

    logic [WIDTH-1:0] out_q;
    logic             zero_q, c_q, ov_q, ill_q;

    logic             in_legal, in_inv;
    logic             op_inv, op_addsub, is_last;
    logic             slt_bit;
    logic [WIDTH-1:0] run_word, slt_word;

    // Decode of the incoming opcode, used only at accept time.
    always_comb begin
        in_legal = 1'b0;
        in_inv   = 1'b0;
        unique case (operacion_i)
            OP_AND, OP_OR, OP_ADD, OP_XOR: in_legal = 1'b1;
            OP_SUB, OP_SLT: begin
                in_legal = 1'b1;
                in_inv   = 1'b1;
            end
            default: in_legal = 1'b0;
        endcase
    end

    assign op_inv    = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign op_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign is_last   = (state_q == S_RUN) && (cnt_q == LAST);

    // Word as it will look after the current slice bit is shifted in.
    assign run_word = {slice_res_i, res_q[WIDTH-1:1]};

    // Less-than is the sign of the difference corrected for overflow.
    assign slt_bit  = set_q ^ (cin_msb_q ^ cout_q);
    assign slt_word = {res_q[WIDTH-1:1], slt_bit};

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and slice drive; slice is idle outside RUN.
    always_comb begin
        state_d        = state_q;
        slice_a_o      = 1'b0;
        slice_b_o      = 1'b0;
        slice_c_o      = 1'b0;
        slice_invert_o = 1'b0;
        slice_op_o     = 4'b0000;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = in_legal ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                slice_a_o      = a_q[0];
                slice_b_o      = b_q[0];
                slice_c_o      = carry_q;
                slice_invert_o = op_inv;
                slice_op_o     = (op_q == OP_SUB) ? OP_ADD : op_q;
                if (is_last) begin
                    state_d = (op_q == OP_SLT) ? S_SLT_FIX : S_DONE;
                end
            end
            S_SLT_FIX: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Operand shifting, carry threading and result/flag capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            op_q      <= 4'b0000;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            cout_q    <= 1'b0;
            set_q     <= 1'b0;
            out_q     <= '0;
            zero_q    <= 1'b0;
            c_q       <= 1'b0;
            ov_q      <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        out_q <= '0;
                        c_q   <= 1'b0;
                        ov_q  <= 1'b0;
                        if (in_legal) begin
                            a_q       <= a_i;
                            b_q       <= b_i;
                            op_q      <= operacion_i;
                            cnt_q     <= '0;
                            carry_q   <= in_inv;
                            res_q     <= '0;
                            cin_msb_q <= 1'b0;
                            cout_q    <= 1'b0;
                            set_q     <= 1'b0;
                            zero_q    <= 1'b0;
                            ill_q     <= 1'b0;
                        end else begin
                            zero_q <= 1'b1;
                            ill_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= run_word;
                    carry_q <= slice_c_i;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (is_last) begin
                        cin_msb_q <= carry_q;
                        cout_q    <= slice_c_i;
                        set_q     <= slice_set_i;
                        if (op_q != OP_SLT) begin
                            out_q  <= run_word;
                            zero_q <= (run_word == '0);
                            c_q    <= op_addsub & slice_c_i;
                            ov_q   <= op_addsub & (carry_q ^ slice_c_i);
                        end
                    end
                end
                S_SLT_FIX: begin
                    res_q  <= slt_word;
                    out_q  <= slt_word;
                    zero_q <= (slt_word == '0);
                    c_q    <= cout_q;
                    ov_q   <= cin_msb_q ^ cout_q;
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign resultado_o  = out_q;
    assign zero_o       = zero_q;
    assign c_o          = c_q;
    assign overflow_o   = ov_q;
    assign illegal_o    = ill_q;
    assign slice_less_o = 1'b0;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Bench for bit_serial_alu_ctrl: behavioural 1-bit slice plus a
// scoreboard of hand-computed results checked on each done_o.
module tb_bit_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [3:0]   operacion_i;
    logic [W-1:0] a_i, b_i;
    logic         busy_o, done_o, zero_o, c_o, overflow_o, illegal_o;
    logic [W-1:0] resultado_o;
    logic         slice_a_o, slice_b_o, slice_c_o;
    logic         slice_invert_o, slice_less_o;
    logic [3:0]   slice_op_o;
    logic         slice_res_i, slice_c_i, slice_set_i;

    always #5 clk = ~clk;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .operacion_i(operacion_i), .a_i(a_i), .b_i(b_i),
        .busy_o(busy_o), .done_o(done_o), .resultado_o(resultado_o),
        .zero_o(zero_o), .c_o(c_o), .overflow_o(overflow_o),
        .illegal_o(illegal_o), .slice_a_o(slice_a_o),
        .slice_b_o(slice_b_o), .slice_c_o(slice_c_o),
        .slice_invert_o(slice_invert_o), .slice_less_o(slice_less_o),
        .slice_op_o(slice_op_o), .slice_res_i(slice_res_i),
        .slice_c_i(slice_c_i), .slice_set_i(slice_set_i)
    );

    // Reference 1-bit ALU slice.
    logic bx, sum;
    always_comb begin
        bx          = slice_b_o ^ slice_invert_o;
        sum         = slice_a_o ^ bx ^ slice_c_o;
        slice_c_i   = (slice_a_o & bx) | (slice_a_o & slice_c_o) | (bx & slice_c_o);
        slice_set_i = sum;
        case (slice_op_o)
            4'b0000: slice_res_i = slice_a_o & bx;
            4'b0001: slice_res_i = slice_a_o | bx;
            4'b0010: slice_res_i = sum;
            4'b0011: slice_res_i = slice_less_o;
            4'b0100: slice_res_i = slice_a_o ^ bx;
            default: slice_res_i = 1'b0;
        endcase
    end

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         z, c, ov, ill;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done_o must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst_i && done_o) begin
            if (sb.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1 expected none");
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_res"}, 32'(resultado_o), 32'(mon_e.res));
                check({mon_e.name, "_zero"}, 32'(zero_o), 32'(mon_e.z));
                check({mon_e.name, "_c"}, 32'(c_o), 32'(mon_e.c));
                check({mon_e.name, "_ov"}, 32'(overflow_o), 32'(mon_e.ov));
                check({mon_e.name, "_ill"}, 32'(illegal_o), 32'(mon_e.ill));
                check({mon_e.name, "_lat"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
                check({mon_e.name, "_busy"}, 32'(busy_o), 32'd1);
            end
        end
    end

    // Drive one request for one cycle; returns in the cycle after accept.
    task automatic issue(input string nm, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic z,
                         input logic c, input logic ov, input logic ill,
                         input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        e.name = nm; e.res = res; e.z = z; e.c = c; e.ov = ov;
        e.ill = ill; e.lat = lat; e.t0 = cyc;
        if (push) sb.push_back(e);
        operacion_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (!busy_o) return;
            @(negedge clk);
        end
        n_run++;
        n_fail++;
        $display("FAIL %s_timeout: got busy_o=1 expected 0", nm);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (done_o) return;
            @(negedge clk);
        end
        n_run++;
        n_fail++;
        $display("FAIL %s_timeout: got done_o=0 expected 1", nm);
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_busy"}, 32'(busy_o), 32'd0);
        check({nm, "_done"}, 32'(done_o), 32'd0);
        check({nm, "_res"}, 32'(resultado_o), 32'd0);
        check({nm, "_zero"}, 32'(zero_o), 32'd0);
        check({nm, "_c"}, 32'(c_o), 32'd0);
        check({nm, "_ov"}, 32'(overflow_o), 32'd0);
        check({nm, "_ill"}, 32'(illegal_o), 32'd0);
        check({nm, "_sop"}, 32'(slice_op_o), 32'd0);
        check({nm, "_sinv"}, 32'(slice_invert_o), 32'd0);
        check({nm, "_sc"}, 32'(slice_c_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0;
        operacion_i = 4'b0000; a_i = '0; b_i = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_i = 1'b0;

        issue("add_ovf", 4'b0010, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 0, 9, 1);
        wait_idle("add_ovf");
        issue("add_wrap", 4'b0010, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 9, 1);
        wait_idle("add_wrap");

        issue("sub_eq", 4'b0110, 8'h05, 8'h05, 8'h00, 1, 1, 0, 0, 9, 1);
        check("sub_first_inv", 32'(slice_invert_o), 32'd1);
        check("sub_first_cin", 32'(slice_c_o), 32'd1);
        check("sub_first_op", 32'(slice_op_o), 32'h2);
        wait_idle("sub_eq");
        issue("sub_neg", 4'b0110, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 0, 9, 1);
        wait_idle("sub_neg");

        issue("slt_lt", 4'b0011, 8'h80, 8'h01, 8'h01, 0, 1, 1, 0, 10, 1);
        check("slt_first_op", 32'(slice_op_o), 32'h3);
        wait_idle("slt_lt");
        issue("slt_ge", 4'b0011, 8'h01, 8'h80, 8'h00, 1, 0, 1, 0, 10, 1);
        wait_idle("slt_ge");
        issue("slt_ovf", 4'b0011, 8'h7F, 8'h80, 8'h00, 1, 0, 1, 0, 10, 1);
        wait_idle("slt_ovf");

        issue("and", 4'b0000, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 9, 1);
        check("and_first_inv", 32'(slice_invert_o), 32'd0);
        wait_idle("and");
        issue("or", 4'b0001, 8'hF0, 8'h3C, 8'hFC, 0, 0, 0, 0, 9, 1);
        wait_idle("or");
        issue("xor", 4'b0100, 8'hF0, 8'h3C, 8'hCC, 0, 0, 0, 0, 9, 1);
        wait_idle("xor");

        issue("illegal", 4'b1111, 8'h12, 8'h34, 8'h00, 1, 0, 0, 1, 1, 1);
        check("illegal_sop", 32'(slice_op_o), 32'd0);
        check("illegal_sa", 32'(slice_a_o), 32'd0);
        wait_idle("illegal");

        // Reset in the middle of a RUN sequence aborts it.
        issue("rst_run", 4'b0010, 8'h7F, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_quiet("rst_run");

        // Start pulsed while busy must not disturb the running op.
        issue("busy_ign", 4'b0010, 8'h03, 8'h04, 8'h07, 0, 0, 0, 0, 9, 1);
        @(negedge clk);
        operacion_i = 4'b0110; a_i = 8'hFF; b_i = 8'h01; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle("busy_ign");

        // Start during the DONE cycle is ignored.
        issue("done_ign", 4'b0001, 8'h0F, 8'h30, 8'h3F, 0, 0, 0, 0, 9, 1);
        wait_done("done_ign");
        operacion_i = 4'b0000; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("done_ign_idle", 32'(busy_o), 32'd0);
        check("done_ign_hold", 32'(resultado_o), 32'h3F);

        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
Sequencer that runs WIDTH-bit operations through a single external 1-bit ALU slice, one bit per cycle, LSB first. It latches operands, drives the slice's a/b/carry/invert/less/operation inputs each cycle and threads the carry between cycles. It shifts slice results into a word register and reports zero, carry and overflow. It sits between the instruction-level control and the 1-bit slice, so a word-wide ALU costs one slice plus this block.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH), width of the bit counter

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  request; accepted only in IDLE
operacion_i  in  4  0000 AND, 0001 OR, 0010 ADD, 0011 SLT (signed), 0100 XOR, 0110 SUB; others illegal
a_i  in  WIDTH  operand A, sampled on accept
b_i  in  WIDTH  operand B, sampled on accept
busy_o  out  1  high from the cycle after accept through the DONE cycle
done_o  out  1  one-cycle pulse; results valid from this cycle
resultado_o  out  WIDTH  result word; held until the next accept
zero_o  out  1  resultado_o == 0
c_o  out  1  carry out of MSB (ADD/SUB/SLT), else 0
overflow_o  out  1  signed overflow (ADD/SUB/SLT), else 0
illegal_o  out  1  set with done_o for an illegal opcode; held like results
slice_a_o  out  1  to slice a_i
slice_b_o  out  1  to slice b_i
slice_c_o  out  1  to slice c_i
slice_invert_o  out  1  to slice invert_i
slice_less_o  out  1  to slice less_i; always 0
slice_op_o  out  4  to slice operacion_i
slice_res_i  in  1  from slice resultado_o
slice_c_i  in  1  from slice c_o
slice_set_i  in  1  from slice set_o

Behaviour:
- States: IDLE, RUN, SLT_FIX, DONE. Reset in any state: IDLE next edge; all outputs and registers 0; slice_op_o 0000.
- IDLE, start_i=1, legal op (cycle T): latch a_q=a_i, b_q=b_i, op_q; cnt=0; carry_q=1 for SUB/SLT, else 0; clear resultado_o, flags; go to RUN.
- IDLE, start_i=1, illegal op: resultado_o=0, illegal_o=1, go to DONE (done_o at T+1). Never drive the slice.
- start_i outside IDLE: ignored, no effect.
- RUN (cycles T+1..T+WIDTH, bit k in cycle T+1+k):
  - slice_a_o=a_q[0], slice_b_o=b_q[0], slice_c_o=carry_q.
  - slice_invert_o=1 for SUB/SLT.
  - slice_op_o = 0010 for ADD/SUB, 0011 for SLT, else op_q.
  - Each edge: a_q, b_q shift right; res_q <= {slice_res_i, res_q[WIDTH-1:1]}; carry_q <= slice_c_i; cnt++.
  - On the MSB cycle (cnt=WIDTH-1): capture cin_msb=carry_q, cout=slice_c_i, set_q=slice_set_i.
  - After MSB: go to SLT_FIX if SLT, else DONE.
- SLT_FIX (one cycle): res_q[0] <= set_q ^ (cin_msb ^ cout); other bits remain 0 (slice returns less=0). Then DONE.
- DONE (one cycle): done_o=1, busy_o=1; outputs reflect final registers; next state IDLE.
- Latency (accept to done_o): WIDTH+1 cycles for non-SLT ops, WIDTH+2 for SLT, 1 for illegal ops.
- Flags:
  - c_o = cout.
  - overflow_o = cin_msb ^ cout for ADD/SUB/SLT.
  - zero_o computed from the final result.
  - For logic ops, c_o=overflow_o=0.
- Outputs: resultado_o/flags registered. They are cleared on accept and hold after DONE until the next accept or reset.
- In all non-RUN states, slice outputs are 0.
- start_i asserted in the DONE cycle is ignored; re-accept is possible from the following IDLE cycle.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01, start at T -> done_o at T+9, resultado_o=0x80, overflow_o=1, c_o=0, zero_o=0.
- SUB a=0x05 b=0x05 -> resultado_o=0x00, zero_o=1, c_o=1, overflow_o=0; slice_invert_o=1 and slice_c_o=1 on the first RUN cycle.
- SLT a=0x80 b=0x01 -> done_o at T+10, resultado_o=0x01. SLT a=0x01 b=0x80 -> 0x00. SLT a=0x7F b=0x80 (overflow case) -> 0x00.
- AND 0xF0/0x3C -> 0x30; OR -> 0xFC; XOR -> 0xCC; c_o=overflow_o=0 for all three.
- op=1111 -> done_o at T+1, illegal_o=1, resultado_o=0, slice_op_o stays 0000.
- rst_i during RUN cycle 4 -> IDLE next edge, all outputs 0. start_i pulsed while busy is ignored: one done_o only, operands unchanged.
